// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, defaults and alignment helper for the load/store unit.
package lsu_pkg;
  localparam logic [31:0] LSU_BASE_ADDR = 32'h0100_0000;
  localparam int LSU_MEM_WORDS = 1024;
  typedef enum logic [1:0] {LSU_BYTE = 2'd0, LSU_HALF = 2'd1, LSU_WORD = 2'd2, LSU_ILL = 2'd3} lsu_size_e;
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, ERR, RESP} lsu_state_e;
  function automatic logic is_misaligned(lsu_size_e size, logic [1:0] off);
    return (size == LSU_HALF && off[0]) || (size == LSU_WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if: request/response handshake plus word-wide memory port.
interface lsu_mem_master_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_err_o;
  logic [31:0] resp_rdata_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_read_en_o;
  logic        mem_write_en_o;
  logic [31:0] mem_rdata_i;
  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, mem_rdata_i,
    output req_ready_o, resp_valid_o, resp_err_o, resp_rdata_o,
    output mem_addr_o, mem_wdata_o, mem_read_en_o, mem_write_en_o
  );
  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  req_ready_o, resp_valid_o, resp_err_o, resp_rdata_o
  );
  modport mem (
    input  mem_addr_o, mem_wdata_o, mem_read_en_o, mem_write_en_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extraction with extension, and sub-word merge into a word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  lsu_size_e   size_i,
  input  logic        unsigned_i,
  output logic [31:0] extract_o,
  output logic [31:0] merge_o
);
  logic [15:0] lo;
  logic [31:0] mask;
  always_comb begin
    lo = 16'(word_i >> {off_i, 3'b000});
    extract_o = size_i == LSU_BYTE ? {{24{~unsigned_i & lo[7]}}, lo[7:0]} :
                size_i == LSU_HALF ? {{16{~unsigned_i & lo[15]}}, lo} : word_i;
    mask = (size_i == LSU_BYTE ? 32'h0000_00ff : size_i == LSU_HALF ? 32'h0000_ffff : 32'hffff_ffff) << {off_i, 3'b000};
    merge_o = (word_i & ~mask) | ((wdata_i << {off_i, 3'b000}) & mask);
  end
endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store initiator; sub-word stores are read-modify-write.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = LSU_BASE_ADDR,
  parameter int          MEM_WORDS = LSU_MEM_WORDS
) (
  input logic            clk,
  input logic            rst,
  lsu_mem_master_if.slave bus
);
  localparam logic [32:0] ADDR_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] ADDR_HI = ADDR_LO + 33'(4 * MEM_WORDS);
  lsu_state_e  state_q, state_d;
  lsu_size_e   size_q, size_d, req_size;
  logic [1:0]  off_q, off_d;
  logic        uns_q, uns_d, err_q, err_d, req_err;
  logic [31:0] data_q, data_d, rdata_q, rdata_d, mem_addr_q, mem_addr_d;
  logic [31:0] ext_word, merged_word;
  assign req_size = lsu_size_e'(bus.req_size_i);
  assign req_err = req_size == LSU_ILL || is_misaligned(req_size, bus.req_addr_i[1:0]) ||
                   {1'b0, bus.req_addr_i} < ADDR_LO || {1'b0, bus.req_addr_i} >= ADDR_HI;
  lsu_lane_align u_align (
    .word_i    (bus.mem_rdata_i),
    .wdata_i   (data_q),
    .off_i     (off_q),
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .extract_o (ext_word),
    .merge_o   (merged_word)
  );
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    off_d      = off_q;
    uns_d      = uns_q;
    err_d      = err_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: if (bus.req_valid_i) begin
        size_d     = req_size;
        off_d      = bus.req_addr_i[1:0];
        uns_d      = bus.req_unsigned_i;
        err_d      = req_err;
        data_d     = bus.req_wdata_i;
        rdata_d    = '0;
        mem_addr_d = {bus.req_addr_i[31:2], 2'b00};
        state_d    = req_err ? ERR : !bus.req_we_i ? LOAD : req_size == LSU_WORD ? WRITE : RMW_RD;
      end
      LOAD: begin
        rdata_d = ext_word;
        state_d = RESP;
      end
      RMW_RD: begin
        data_d  = merged_word;
        state_d = WRITE;
      end
      WRITE, ERR: state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      size_q     <= LSU_BYTE;
      off_q      <= '0;
      uns_q      <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      off_q      <= off_d;
      uns_q      <= uns_d;
      err_q      <= err_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      mem_addr_q <= mem_addr_d;
    end
  end
  assign bus.req_ready_o    = state_q == IDLE;
  assign bus.resp_valid_o   = state_q == RESP;
  assign bus.resp_err_o     = state_q == RESP && err_q;
  assign bus.resp_rdata_o   = rdata_q;
  assign bus.mem_addr_o     = mem_addr_q;
  assign bus.mem_wdata_o    = data_q;
  assign bus.mem_read_en_o  = state_q == LOAD || state_q == RMW_RD;
  assign bus.mem_write_en_o = state_q == WRITE;
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: scenario tasks with a response scoreboard against a behavioural word memory.
module tb_lsu_mem_master;
  typedef struct {logic err; logic [31:0] rdata; int lat;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0, failures = 0, both_hi = 0;
  exp_t sb[$];
  logic [31:0] mem [0:1023];
  lsu_mem_master_if bus ();
  lsu_mem_master dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_rdata_i = mem[bus.mem_addr_o[11:2]];
  always @(posedge clk) if (bus.mem_write_en_o) mem[bus.mem_addr_o[11:2]] <= bus.mem_wdata_o;
  always @(negedge clk) if (bus.mem_read_en_o && bus.mem_write_en_o) both_hi <= both_hi + 1;

  task automatic preload();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = 32'hfd01_0113;
    mem[1] = 32'h0211_2623;
  endtask

  task automatic xact(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      output int lat, output int rd_n, output int wr_n, output int rd_cyc, output int wr_cyc,
                      output logic [31:0] wd, output logic err, output logic [31:0] rdata);
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_size_i = size;
    bus.req_unsigned_i = uns; bus.req_addr_i = addr; bus.req_wdata_i = wdata;
    @(posedge clk);
    lat = -1; rd_n = 0; wr_n = 0; rd_cyc = 0; wr_cyc = 0; wd = '0; err = 1'bx; rdata = 'x;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      if (bus.mem_read_en_o) begin rd_n++; rd_cyc = c; end
      if (bus.mem_write_en_o) begin wr_n++; wr_cyc = c; wd = bus.mem_wdata_o; end
      if (bus.resp_valid_o) begin lat = c; err = bus.resp_err_o; rdata = bus.resp_rdata_o; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks += 5;
    if (bus.req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", bus.req_ready_o); end
    if (bus.resp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_resp got=%b want=0", bus.resp_valid_o); end
    if (bus.mem_addr_o !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h want=0", bus.mem_addr_o); end
    if (bus.mem_read_en_o !== 1'b0) begin failures++; $display("FAIL reset_read_en got=%b want=0", bus.mem_read_en_o); end
    if (bus.mem_write_en_o !== 1'b0) begin failures++; $display("FAIL reset_write_en got=%b want=0", bus.mem_write_en_o); end
  endtask

  task automatic test_lw();
    int lat, rd_n, wr_n, rd_cyc, wr_cyc; logic [31:0] wd, rdata; logic err; exp_t e;
    preload();
    sb.push_back('{1'b0, 32'hfd01_0113, 2});
    xact(1'b0, 2'd2, 1'b0, 32'h0100_0000, 32'h0, lat, rd_n, wr_n, rd_cyc, wr_cyc, wd, err, rdata);
    e = sb.pop_front();
    checks += 5;
    if (lat !== e.lat) begin failures++; $display("FAIL lw_latency got=%0d want=%0d", lat, e.lat); end
    if (rdata !== e.rdata) begin failures++; $display("FAIL lw_rdata got=%h want=%h", rdata, e.rdata); end
    if (err !== e.err) begin failures++; $display("FAIL lw_err got=%b want=%b", err, e.err); end
    if (rd_n !== 1) begin failures++; $display("FAIL lw_read_cycles got=%0d want=1", rd_n); end
    if (wr_n !== 0) begin failures++; $display("FAIL lw_write_cycles got=%0d want=0", wr_n); end
  endtask

  task automatic test_subword_loads();
    int lat, rd_n, wr_n, rd_cyc, wr_cyc; logic [31:0] wd, rdata; logic err; exp_t e;
    logic [1:0]  sz  [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic        un  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad  [4] = '{32'h0100_0003, 32'h0100_0003, 32'h0100_0002, 32'h0100_0000};
    logic [31:0] exv [4] = '{32'hffff_fffd, 32'h0000_00fd, 32'hffff_fd01, 32'h0000_0113};
    preload();
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{1'b0, exv[i], 2});
      xact(1'b0, sz[i], un[i], ad[i], 32'h0, lat, rd_n, wr_n, rd_cyc, wr_cyc, wd, err, rdata);
      e = sb.pop_front();
      checks += 3;
      if (rdata !== e.rdata) begin failures++; $display("FAIL subload%0d_rdata got=%h want=%h", i, rdata, e.rdata); end
      if (err !== e.err) begin failures++; $display("FAIL subload%0d_err got=%b want=%b", i, err, e.err); end
      if (lat !== e.lat) begin failures++; $display("FAIL subload%0d_latency got=%0d want=%0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_sb();
    int lat, rd_n, wr_n, rd_cyc, wr_cyc; logic [31:0] wd, rdata; logic err; exp_t e;
    preload();
    sb.push_back('{1'b0, 32'h0, 3});
    xact(1'b1, 2'd0, 1'b0, 32'h0100_0005, 32'h1234_56aa, lat, rd_n, wr_n, rd_cyc, wr_cyc, wd, err, rdata);
    e = sb.pop_front();
    checks += 8;
    if (lat !== e.lat) begin failures++; $display("FAIL sb_latency got=%0d want=%0d", lat, e.lat); end
    if (rd_n !== 1 || rd_cyc !== 1) begin failures++; $display("FAIL sb_read got=%0d@%0d want=1@1", rd_n, rd_cyc); end
    if (wr_n !== 1 || wr_cyc !== 2) begin failures++; $display("FAIL sb_write got=%0d@%0d want=1@2", wr_n, wr_cyc); end
    if (wd !== 32'h0211_aa23) begin failures++; $display("FAIL sb_wdata got=%h want=0211aa23", wd); end
    if (err !== e.err) begin failures++; $display("FAIL sb_err got=%b want=%b", err, e.err); end
    if (rdata !== e.rdata) begin failures++; $display("FAIL sb_rdata got=%h want=%h", rdata, e.rdata); end
    sb.push_back('{1'b0, 32'h0211_aa23, 2});
    xact(1'b0, 2'd2, 1'b0, 32'h0100_0004, 32'h0, lat, rd_n, wr_n, rd_cyc, wr_cyc, wd, err, rdata);
    e = sb.pop_front();
    if (rdata !== e.rdata) begin failures++; $display("FAIL sb_readback got=%h want=%h", rdata, e.rdata); end
    if (mem[0] !== 32'hfd01_0113) begin failures++; $display("FAIL sb_neighbour got=%h want=fd010113", mem[0]); end
  endtask

  task automatic test_errors();
    int lat, rd_n, wr_n, rd_cyc, wr_cyc; logic [31:0] wd, rdata; logic err; exp_t e;
    logic        we [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  sz [3] = '{2'd2, 2'd2, 2'd3};
    logic [31:0] ad [3] = '{32'h0100_0002, 32'h0000_0000, 32'h0100_0000};
    preload();
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{1'b1, 32'h0, 2});
      xact(we[i], sz[i], 1'b0, ad[i], 32'hdead_beef, lat, rd_n, wr_n, rd_cyc, wr_cyc, wd, err, rdata);
      e = sb.pop_front();
      checks += 4;
      if (err !== e.err) begin failures++; $display("FAIL err%0d_flag got=%b want=%b", i, err, e.err); end
      if (rdata !== e.rdata) begin failures++; $display("FAIL err%0d_rdata got=%h want=%h", i, rdata, e.rdata); end
      if (lat !== e.lat) begin failures++; $display("FAIL err%0d_latency got=%0d want=%0d", i, lat, e.lat); end
      if (rd_n + wr_n !== 0) begin failures++; $display("FAIL err%0d_enables got=%0d want=0", i, rd_n + wr_n); end
    end
    checks++;
    if (mem[0] !== 32'hfd01_0113) begin failures++; $display("FAIL err_mem_intact got=%h want=fd010113", mem[0]); end
  endtask

  task automatic test_reset_mid_rmw();
    int wr_n = 0, resp_n = 0; logic rd_seen;
    preload();
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = 2'd0;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h0100_0005; bus.req_wdata_i = 32'h1234_56aa;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    rd_seen = bus.mem_read_en_o;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rst = 1'b1;
      if (bus.mem_write_en_o) wr_n++;
      if (bus.resp_valid_o) resp_n++;
    end
    checks += 5;
    if (rd_seen !== 1'b1) begin failures++; $display("FAIL rmw_rst_read got=%b want=1", rd_seen); end
    if (wr_n !== 0) begin failures++; $display("FAIL rmw_rst_write got=%0d want=0", wr_n); end
    if (resp_n !== 0) begin failures++; $display("FAIL rmw_rst_resp got=%0d want=0", resp_n); end
    if (mem[1] !== 32'h0211_2623) begin failures++; $display("FAIL rmw_rst_mem got=%h want=02112623", mem[1]); end
    if (bus.req_ready_o !== 1'b1) begin failures++; $display("FAIL rmw_rst_ready got=%b want=1", bus.req_ready_o); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int acc_cyc[2] = '{-1, -1};
    int resp_cyc[2] = '{-1, -1};
    int n_acc = 0, n_resp = 0, busy_bad = 0;
    logic [31:0] addrs[2] = '{32'h0100_0000, 32'h0100_0004};
    preload();
    sb.push_back('{1'b0, 32'hfd01_0113, 2});
    sb.push_back('{1'b0, 32'h0211_2623, 2});
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_size_i = 2'd2;
    bus.req_unsigned_i = 1'b0; bus.req_wdata_i = 32'h0;
    for (int c = 0; c < 14 && n_resp < 2; c++) begin
      if (c > 0) @(negedge clk);
      if (n_acc > n_resp && bus.req_ready_o) busy_bad++;
      if (bus.resp_valid_o) begin
        e = sb.pop_front();
        checks += 2;
        if (bus.resp_rdata_o !== e.rdata) begin failures++; $display("FAIL b2b%0d_rdata got=%h want=%h", n_resp, bus.resp_rdata_o, e.rdata); end
        if (bus.resp_err_o !== e.err) begin failures++; $display("FAIL b2b%0d_err got=%b want=%b", n_resp, bus.resp_err_o, e.err); end
        resp_cyc[n_resp] = c;
        n_resp++;
      end
      if (n_acc >= 2) bus.req_valid_i = 1'b0;
      else bus.req_addr_i = addrs[n_acc];
      if (bus.req_valid_i && bus.req_ready_o) begin acc_cyc[n_acc] = c; n_acc++; end
    end
    bus.req_valid_i = 1'b0;
    checks += 3;
    if (n_resp !== 2) begin failures++; $display("FAIL b2b_resp_count got=%0d want=2", n_resp); end
    if (busy_bad !== 0) begin failures++; $display("FAIL b2b_ready_busy got=%0d want=0", busy_bad); end
    if (acc_cyc[1] !== resp_cyc[0] + 1) begin failures++; $display("FAIL b2b_second_accept got=%0d want=%0d", acc_cyc[1], resp_cyc[0] + 1); end
  endtask

  task automatic test_enables();
    checks++;
    if (both_hi !== 0) begin failures++; $display("FAIL enables_overlap got=%0d want=0", both_hi); end
  endtask

  initial begin
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'd0;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
    preload();
    test_reset();
    test_lw();
    test_subword_loads();
    test_sb();
    test_errors();
    test_reset_mid_rmw();
    test_back_to_back();
    test_enables();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
Load/store initiator that drives the word-wide memory port: addr_i, data_i, read_en_i, write_en_i and data_o. That memory reads combinationally and writes on posedge.
- Accepts byte/half/word load and store requests over a valid/ready handshake.
- Aligns load data and sign/zero-extends it.
- Implements sub-word stores as read-modify-write, because the memory has no byte enables.
- Sits between the pd execute/memory stage and the memory module.

Parameters:
BASE_ADDR, 32'h0100_0000, lowest legal byte address
MEM_WORDS, 1024, memory depth in 32-bit words; legal range is [BASE_ADDR, BASE_ADDR+4*MEM_WORDS)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low (sampled on posedge clk; 0 = reset)
req_valid_i  in  1  request valid
req_ready_o  out  1  high only in IDLE
req_we_i  in  1  1=store, 0=load
req_size_i  in  2  0=byte, 1=half, 2=word, 3=illegal
req_unsigned_i  in  1  zero-extend loads (LBU/LHU)
req_addr_i  in  32  byte address
req_wdata_i  in  32  store data, right-justified
resp_valid_o  out  1  one-cycle completion pulse
resp_err_o  out  1  misaligned, out-of-range or illegal size; valid with resp_valid_o
resp_rdata_o  out  32  extended load data; 0 for stores and errors
mem_addr_o  out  32  word-aligned address to memory addr_i
mem_wdata_o  out  32  to memory data_i
mem_read_en_o  out  1  to memory read_en_i
mem_write_en_o  out  1  to memory write_en_i
mem_rdata_i  in  32  from memory data_o (combinational)

Behaviour:
- Reset (rst==0 at posedge):
  - state returns to IDLE and all registered outputs clear to 0.
  - req_ready_o goes to 1 after reset releases.
  - An in-flight operation is aborted: no write issued, no response issued.
- States and transitions:
  - IDLE: handshake completes when req_valid_i & req_ready_o.
    - Latch request.
    - Error check: misaligned (half with addr[0]; word with addr[1:0]!=0), address out of range, or size==3 -> ERR.
    - Load -> LOAD.
    - Store word -> WRITE, with merged data = req_wdata_i.
    - Store byte/half -> RMW_RD.
  - LOAD: mem_read_en_o=1 and mem_addr_o={addr[31:2],2'b00}. Capture mem_rdata_i in the same cycle. Select lane by addr[1:0] (little-endian), extend per size/unsigned -> RESP.
  - RMW_RD: mem_read_en_o=1. Capture word, replace the addressed byte/half lane with the low bits of wdata -> WRITE.
  - WRITE: mem_write_en_o=1 for exactly this one cycle, mem_wdata_o=merged word. The memory commits on the posedge ending this cycle -> RESP.
  - ERR: no memory enables -> RESP with err flag set.
  - RESP: resp_valid_o=1 for one cycle -> IDLE.
- Latency, counted from the accept edge: error 2 cycles; load and word store 2; sub-word store 3.
- Throughput: one request in flight; the next request can be accepted the cycle after RESP.
- Enables: mem_read_en_o and mem_write_en_o are never high together. Both are 0 in IDLE, ERR and RESP.
- mem_addr_o holds the last aligned address outside active states; it is 0 after reset.
- Responses have no backpressure: resp_valid_o must be consumed when pulsed.
- Request inputs are ignored while req_ready_o=0.

Decomposition:
- lsu_pkg:
  - size enum: LSU_BYTE, LSU_HALF, LSU_WORD.
  - lsu_state_e: IDLE, LOAD, RMW_RD, WRITE, ERR, RESP.
  - function is_misaligned(size, addr[1:0]).
- One sub-module, lsu_lane_align. It is combinational and provides:
  - extract(word, offset, size, unsigned) -> 32b.
  - merge(old_word, wdata, offset, size) -> 32b.
- lsu_mem_master holds the FSM, request registers and response registers.

Test Plan:
All scenarios use memory preloaded with 0x01000000=fd010113 and 0x01000004=02112623.
- LW 0x01000000: resp_valid_o 2 cycles after accept; rdata=fd010113; err=0; exactly one read_en cycle; no write_en.
- Sub-word loads:
  - LB 0x01000003 -> fffffffd.
  - LBU 0x01000003 -> 000000fd.
  - LH 0x01000002 -> fffffd01.
  - LHU 0x01000000 -> 00000113.
- SB 0x01000005, wdata 0x123456AA:
  - read_en in cycle 1, write_en only in cycle 2 with mem_wdata_o=0211AA23, resp in cycle 3.
  - A follow-up LW 0x01000004 returns 0211AA23.
- Error cases, each giving err=1, rdata=0, resp 2 cycles after accept, and no read_en/write_en ever asserted:
  - LW 0x01000002 (misaligned).
  - SW 0x00000000 (out of range).
  - size=3 (illegal).
- Reset mid-RMW: drive rst=0 at the posedge ending RMW_RD. Required: no write_en, word at 0x01000004 still 02112623, no resp_valid_o, req_ready_o=1 once rst=1.
- Back-to-back: req_valid_i held high with two LWs. req_ready_o must be 0 from accept through RESP; second accept occurs the cycle after the first resp pulse; responses arrive in order.
